// File: rtl/lr_pkg.sv
// Shared fixed-point constants and FSM state type for the statistics stage.
package lr_pkg;

    localparam int FIX_W  = 16;
    localparam int FRAC_W = 4;
    localparam int PROD_W = 32;

    localparam logic [FIX_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [FIX_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN1,
        ST_DRAIN2,
        ST_DONE
    } proc_state_t;

endpackage

// File: rtl/avg_shift_sat.sv
// Arithmetic right shift (floor) of a signed sum, then saturation to sfix16.
module avg_shift_sat
    import lr_pkg::*;
#(
    parameter int IN_W  = 20,
    parameter int SHIFT = 4
) (
    input  logic signed [IN_W-1:0]  i_sum,
    output logic        [FIX_W-1:0] o_avg
);

    logic signed [IN_W-1:0] w_shifted;

    // Shift, then clamp whenever the bits above the 16-bit result are not pure sign extension
    always_comb begin
        w_shifted = i_sum >>> SHIFT;
        if ((&w_shifted[IN_W-1:FIX_W-1]) || ~(|w_shifted[IN_W-1:FIX_W-1])) begin
            o_avg = w_shifted[FIX_W-1:0];
        end else if (w_shifted[IN_W-1]) begin
            o_avg = SAT_MIN;
        end else begin
            o_avg = SAT_MAX;
        end
    end

endmodule

// File: rtl/data_proc.sv
// Block statistics: accumulates sums of x, y, x^2, y^2, xy over 2^LOG2_N samples
// and emits the five block averages in sfix16_En4 with a one-cycle valid pulse.
module data_proc
    import lr_pkg::*;
#(
    parameter int LOG2_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [FIX_W-1:0] x_in,
    input  logic [FIX_W-1:0] y_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             busy,
    output logic [FIX_W-1:0] x_avg,
    output logic [FIX_W-1:0] y_avg,
    output logic [FIX_W-1:0] x_sqr_avg,
    output logic [FIX_W-1:0] y_sqr_avg,
    output logic [FIX_W-1:0] x_mul_y_avg,
    output logic             avg_valid_out
);

    localparam int          CNT_W     = LOG2_N + 1;
    localparam int          SUM_W     = FIX_W + LOG2_N;
    localparam int          SQS_W     = PROD_W + LOG2_N;
    localparam int unsigned N_SAMPLES = 1 << LOG2_N;

    proc_state_t r_state, w_next;

    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_ready;
    logic             w_busy;
    logic             w_cnt_full;

    logic                     r_v0, r_v1;
    logic signed [FIX_W-1:0]  r_x0, r_y0, r_x1, r_y1;
    logic signed [PROD_W-1:0] r_xx1, r_yy1, r_xy1;

    logic signed [SUM_W-1:0]  r_sx, r_sy;
    logic signed [SQS_W-1:0]  r_sxx, r_syy, r_sxy;

    logic [FIX_W-1:0] w_x_avg, w_y_avg, w_xx_avg, w_yy_avg, w_xy_avg;
    logic [FIX_W-1:0] r_x_avg, r_y_avg, r_xx_avg, r_yy_avg, r_xy_avg;
    logic             r_avg_valid;

    assign w_cnt_full = (r_cnt == CNT_W'(N_SAMPLES));
    assign w_accept   = sample_valid && w_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; ACCUM holds one extra cycle after the
    // last acceptance (ready already low) so the drain states line up with the
    // two-deep sample pipeline below.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_busy  = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_ready = !w_cnt_full;
                if (w_cnt_full) begin
                    w_next = ST_DRAIN1;
                end
            end
            ST_DRAIN1: w_next = ST_DRAIN2;
            ST_DRAIN2: w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign sample_ready = w_ready;
    assign busy         = w_busy;

    // Sample pipeline: capture the accepted pair, then form the full-precision products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0  <= 1'b0;
            r_v1  <= 1'b0;
            r_x0  <= '0;
            r_y0  <= '0;
            r_x1  <= '0;
            r_y1  <= '0;
            r_xx1 <= '0;
            r_yy1 <= '0;
            r_xy1 <= '0;
        end else begin
            r_v0 <= w_accept;
            r_v1 <= r_v0;
            if (w_accept) begin
                r_x0 <= x_in;
                r_y0 <= y_in;
            end
            if (r_v0) begin
                r_x1  <= r_x0;
                r_y1  <= r_y0;
                r_xx1 <= PROD_W'(r_x0) * PROD_W'(r_x0);
                r_yy1 <= PROD_W'(r_y0) * PROD_W'(r_y0);
                r_xy1 <= PROD_W'(r_x0) * PROD_W'(r_y0);
            end
        end
    end

    // Sample counter and accumulators, cleared by an honoured start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sx  <= '0;
            r_sy  <= '0;
            r_sxx <= '0;
            r_syy <= '0;
            r_sxy <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_cnt <= '0;
            r_sx  <= '0;
            r_sy  <= '0;
            r_sxx <= '0;
            r_syy <= '0;
            r_sxy <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_v1) begin
                r_sx  <= r_sx  + SUM_W'(r_x1);
                r_sy  <= r_sy  + SUM_W'(r_y1);
                r_sxx <= r_sxx + SQS_W'(r_xx1);
                r_syy <= r_syy + SQS_W'(r_yy1);
                r_sxy <= r_sxy + SQS_W'(r_xy1);
            end
        end
    end

    avg_shift_sat #(.IN_W(SUM_W), .SHIFT(LOG2_N)) u_x_avg (
        .i_sum (r_sx),
        .o_avg (w_x_avg)
    );

    avg_shift_sat #(.IN_W(SUM_W), .SHIFT(LOG2_N)) u_y_avg (
        .i_sum (r_sy),
        .o_avg (w_y_avg)
    );

    avg_shift_sat #(.IN_W(SQS_W), .SHIFT(LOG2_N + FRAC_W)) u_xx_avg (
        .i_sum (r_sxx),
        .o_avg (w_xx_avg)
    );

    avg_shift_sat #(.IN_W(SQS_W), .SHIFT(LOG2_N + FRAC_W)) u_yy_avg (
        .i_sum (r_syy),
        .o_avg (w_yy_avg)
    );

    avg_shift_sat #(.IN_W(SQS_W), .SHIFT(LOG2_N + FRAC_W)) u_xy_avg (
        .i_sum (r_sxy),
        .o_avg (w_xy_avg)
    );

    // Register averages once the accumulators are final; valid pulses for the DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_avg     <= '0;
            r_y_avg     <= '0;
            r_xx_avg    <= '0;
            r_yy_avg    <= '0;
            r_xy_avg    <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= (r_state == ST_DRAIN2);
            if (r_state == ST_DRAIN2) begin
                r_x_avg  <= w_x_avg;
                r_y_avg  <= w_y_avg;
                r_xx_avg <= w_xx_avg;
                r_yy_avg <= w_yy_avg;
                r_xy_avg <= w_xy_avg;
            end
        end
    end

    assign x_avg         = r_x_avg;
    assign y_avg         = r_y_avg;
    assign x_sqr_avg     = r_xx_avg;
    assign y_sqr_avg     = r_yy_avg;
    assign x_mul_y_avg   = r_xy_avg;
    assign avg_valid_out = r_avg_valid;

endmodule

// File: tb/tb_data_proc.sv
// Scoreboard bench for data_proc (LOG2_N = 4): directed blocks push hand-computed
// averages; a negedge monitor pops and compares on every avg_valid_out.
module tb_data_proc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic        sample_ready, busy, avg_valid_out;
    logic [15:0] x_avg, y_avg, x_sqr_avg, y_sqr_avg, x_mul_y_avg;

    data_proc #(.LOG2_N(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .x_in          (x_in),
        .y_in          (y_in),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .busy          (busy),
        .x_avg         (x_avg),
        .y_avg         (y_avg),
        .x_sqr_avg     (x_sqr_avg),
        .y_sqr_avg     (y_sqr_avg),
        .x_mul_y_avg   (x_mul_y_avg),
        .avg_valid_out (avg_valid_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] xa;
        logic [15:0] ya;
        logic [15:0] xx;
        logic [15:0] yy;
        logic [15:0] xy;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          last_acc = 0;
    logic [15:0] bx[16];
    logic [15:0] by[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected block
    always @(negedge clk) begin
        if (rst_n && avg_valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got pulse expected none (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("x_avg", x_avg, mon_e.xa);
                check("y_avg", y_avg, mon_e.ya);
                check("x_sqr_avg", x_sqr_avg, mon_e.xx);
                check("y_sqr_avg", y_sqr_avg, mon_e.yy);
                check("x_mul_y_avg", x_mul_y_avg, mon_e.xy);
                check("pulse_latency", cyc - last_acc, 3);
            end
        end
    end

    task automatic start_block();
        check("ready_idle", sample_ready, 0);
        check("busy_idle", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_accum", sample_ready, 1);
        check("busy_accum", busy, 1);
    endtask

    task automatic send(input logic [15:0] xv, input logic [15:0] yv, input int gap, input bit poke);
        int waited;
        repeat (gap) begin
            sample_valid = 1'b0;
            start = poke;
            @(negedge clk);
        end
        start = 1'b0;
        x_in = xv;
        y_in = yv;
        sample_valid = 1'b1;
        waited = 0;
        while (!sample_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!sample_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
        end else begin
            last_acc = cyc + 1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) @(negedge clk);
            check("ready_low_after_last", sample_ready, 0);
            if (k == 3) check("busy_in_done", busy, 1);
            if (k == 4) check("busy_fall", busy, 0);
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_block(input exp_t e, input bit gaps);
        exp_q.push_back(e);
        start_block();
        for (int i = 0; i < 16; i++) begin
            send(bx[i], by[i], gaps ? int'($urandom_range(0, 3)) : 0, gaps);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_x_avg", x_avg, 0);
        check("rst_valid", avg_valid_out, 0);
        check("rst_ready", sample_ready, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // sample_valid in IDLE must be ignored
        sample_valid = 1'b1;
        x_in = 16'h1234;
        repeat (2) @(negedge clk);
        check("idle_ignores_valid", busy, 0);
        sample_valid = 1'b0;

        // x = 1.0, y = 2.0
        for (int i = 0; i < 16; i++) begin bx[i] = 16'h0010; by[i] = 16'h0020; end
        run_block('{16'h0010, 16'h0020, 16'h0010, 16'h0040, 16'h0020}, 1'b0);

        // x = -1.5, y = 1.0
        for (int i = 0; i < 16; i++) begin bx[i] = 16'hFFE8; by[i] = 16'h0010; end
        run_block('{16'hFFE8, 16'h0010, 16'h0024, 16'h0010, 16'hFFE8}, 1'b0);

        // floor rounding: +1 LSB / 0 alternating, then -1 LSB / 0
        for (int i = 0; i < 16; i++) begin bx[i] = (i % 2 == 0) ? 16'h0001 : 16'h0000; by[i] = 16'h0000; end
        run_block('{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b0);
        for (int i = 0; i < 16; i++) begin bx[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000; by[i] = 16'h0000; end
        run_block('{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b0);

        // saturation at both extremes
        for (int i = 0; i < 16; i++) begin bx[i] = 16'h7FFF; by[i] = 16'h7FFF; end
        run_block('{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 1'b0);
        for (int i = 0; i < 16; i++) begin bx[i] = 16'h8000; by[i] = 16'h8000; end
        run_block('{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 1'b0);

        // ramp x = i, y = 3.0 with random gaps and start poked during ACCUM
        for (int i = 0; i < 16; i++) begin bx[i] = 16'(i * 16); by[i] = 16'h0030; end
        run_block('{16'h0078, 16'h0030, 16'h04D8, 16'h0090, 16'h0168}, 1'b1);

        // reset after 7 samples: outputs clear at once, no pulse
        start_block();
        for (int i = 0; i < 7; i++) send(16'h0100, 16'h0100, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_x_avg", x_avg, 0);
        check("midrst_x_sqr", x_sqr_avg, 0);
        check("midrst_xy", x_mul_y_avg, 0);
        check("midrst_ready", sample_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", avg_valid_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // fresh block after reset: x = 4.0, y = -1.0
        for (int i = 0; i < 16; i++) begin bx[i] = 16'h0040; by[i] = 16'hFFF0; end
        run_block('{16'h0040, 16'hFFF0, 16'h0100, 16'h0010, 16'hFFC0}, 1'b0);

        repeat (6) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
